// File: rtl/if_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the reset/NOP constants, the PC step and the fetch FSM states.
package if_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // Sequential successor of a word address; the carry out of bit 31 is dropped.
  function automatic logic [31:0] next_pc(input logic [31:0] addr);
    return addr + PC_INC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry instruction buffer sitting in front of the IF/ID register.
// Clear beats load, and load beats drain, so a same-edge drain and load keeps the new entry.
module if_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst  <= 32'h0;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_inst  <= i_inst;
        r_pc    <= i_pc;
        r_valid <= 1'b1;
      end else if (i_drain) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC sequencing, request/response handshake with
// instruction memory, branch redirect, and a DRAIN state that swallows a stale in-flight fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = if_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  import if_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_addr;
  logic         r_pend;

  logic         w_req;
  logic [31:0]  w_addr;
  logic         w_xfer;
  logic         w_load;
  logic         w_clear;
  logic [31:0]  w_buf_inst;
  logic [31:0]  w_buf_pc;
  logic         w_buf_valid;

  // A pending address is held on the bus until it completes, even if the request drops.
  always_comb begin
    w_req  = 1'b1;
    w_addr = r_req_addr;
    case (r_state)
      ST_RUN: begin
        w_req  = !w_buf_valid || !freeze;
        w_addr = r_pend ? r_req_addr : r_pc;
      end
      ST_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
      end
      default: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
      end
    endcase
  end

  assign w_xfer = w_req && imem_ready;

  // A redirect with a fetch still outstanding (old or just issued) must wait for it to retire.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (branch_taken && !w_xfer && (r_pend || w_req))
          w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!branch_taken && w_xfer)
          w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_load  = (r_state == ST_RUN) && w_xfer && !branch_taken;
  assign w_clear = branch_taken || (r_state == ST_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_req_addr <= 32'h0;
      r_pend     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_pend <= 1'b0;
      end else if (w_req && !imem_ready) begin
        r_pend     <= 1'b1;
        r_req_addr <= w_addr;
      end
      if (branch_taken)
        r_pc <= branch_addr;
      else if (w_load)
        r_pc <= next_pc(w_addr);
    end
  end

  if_skid_buf u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_drain (!freeze),
    .i_clear (w_clear),
    .i_inst  (imem_rdata),
    .i_pc    (w_addr),
    .o_inst  (w_buf_inst),
    .o_pc    (w_buf_pc),
    .o_valid (w_buf_valid)
  );

  assign imem_req   = w_req;
  assign imem_addr  = w_addr;
  assign pc_out     = next_pc(w_buf_pc);
  assign inst_out   = w_buf_valid ? w_buf_inst : NOP_INST;
  assign inst_valid = w_buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the fetch stage.
module tb_if_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  if_fetch_unit #(.RESET_PC(TB_RESET_PC), .NOP_INST(TB_NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .inst_valid   (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: next fetch address, one outstanding memory address,
  // a "discard next response" flag, and the buffered instruction.
  logic [31:0] mPc, mBufInst, mBufPc, mOutAddr;
  logic        mBufValid, mHaveOut, mDiscard;

  logic        expReq, expValid;
  logic [31:0] expAddr, expInst, expPcOut;
  logic        obsReq, obsValid;
  logic [31:0] obsAddr, obsInst, obsPcOut;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic modelReset();
    mPc = TB_RESET_PC; mBufInst = 32'h0; mBufPc = 32'h0; mOutAddr = 32'h0;
    mBufValid = 1'b0; mHaveOut = 1'b0; mDiscard = 1'b0;
  endtask

  // Drives one clock cycle (entered at posedge+1), samples the DUT at the falling edge,
  // and advances the model across the rising edge.
  task automatic applyStimulus(input logic f, input logic b, input logic [31:0] ba, input logic rdy);
    logic xfer;
    freeze = f; branch_taken = b; branch_addr = ba; imem_ready = rdy;
    expReq   = mDiscard ? 1'b1 : (!mBufValid || !f);
    expAddr  = (mDiscard || mHaveOut) ? mOutAddr : mPc;
    expValid = mBufValid;
    expInst  = mBufValid ? mBufInst : TB_NOP;
    expPcOut = mBufPc + 32'd4;
    imem_rdata = memFn(expAddr);
    @(negedge clk);
    obsReq = imem_req; obsAddr = imem_addr; obsValid = inst_valid;
    obsInst = inst_out; obsPcOut = pc_out;
    xfer = expReq && rdy;
    if (b) begin
      if (!mDiscard && !xfer && (mHaveOut || expReq)) mDiscard = 1'b1;
      mPc = ba;
      mBufValid = 1'b0;
    end else if (mDiscard) begin
      if (xfer) mDiscard = 1'b0;
    end else if (xfer) begin
      mBufInst = memFn(expAddr); mBufPc = expAddr; mBufValid = 1'b1;
      mPc = expAddr + 32'd4;
    end else if (!f) begin
      mBufValid = 1'b0;
    end
    if (xfer) mHaveOut = 1'b0;
    else if (expReq && !rdy) begin mHaveOut = 1'b1; mOutAddr = expAddr; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    #1;
    nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_req: got %b want 1", imem_req); end
    nCompared++; if (imem_addr !== TB_RESET_PC) begin nMismatched++; $display("[TB] FAIL reset_addr: got %h want %h", imem_addr, TB_RESET_PC); end
    nCompared++; if (pc_out !== 32'h4) begin nMismatched++; $display("[TB] FAIL reset_pc_out: got %h want 4", pc_out); end
    nCompared++; if (inst_out !== TB_NOP) begin nMismatched++; $display("[TB] FAIL reset_inst: got %h want %h", inst_out, TB_NOP); end
    nCompared++; if (inst_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", inst_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wantPcOut, wantInst;
      wantPcOut = (i == 0) ? 32'd4 : 32'(4 * i);
      wantInst  = (i == 0) ? TB_NOP : memFn(32'(4 * (i - 1)));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      nCompared++; if (obsAddr !== 32'(4 * i)) begin nMismatched++; $display("[TB] FAIL seq_addr[%0d]: got %h want %h", i, obsAddr, 32'(4 * i)); end
      nCompared++; if (obsValid !== (i > 0)) begin nMismatched++; $display("[TB] FAIL seq_valid[%0d]: got %b want %b", i, obsValid, (i > 0)); end
      nCompared++; if (obsPcOut !== wantPcOut) begin nMismatched++; $display("[TB] FAIL seq_pc_out[%0d]: got %h want %h", i, obsPcOut, wantPcOut); end
      nCompared++; if (obsInst !== wantInst) begin nMismatched++; $display("[TB] FAIL seq_inst[%0d]: got %h want %h", i, obsInst, wantInst); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, (i == 2));
      nCompared++; if (obsAddr !== 32'h10) begin nMismatched++; $display("[TB] FAIL stall_addr[%0d]: got %h want 10", i, obsAddr); end
      nCompared++; if (obsReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_req[%0d]: got %b want 1", i, obsReq); end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsPcOut !== 32'h14) begin nMismatched++; $display("[TB] FAIL stall_pc_out: got %h want 14", obsPcOut); end
    nCompared++; if (obsInst !== memFn(32'h10)) begin nMismatched++; $display("[TB] FAIL stall_inst: got %h want %h", obsInst, memFn(32'h10)); end
    nCompared++; if (obsValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_valid: got %b want 1", obsValid); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      nCompared++; if (obsReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL frz_req[%0d]: got %b want 0", i, obsReq); end
      nCompared++; if (obsPcOut !== 32'h18) begin nMismatched++; $display("[TB] FAIL frz_pc_out[%0d]: got %h want 18", i, obsPcOut); end
      nCompared++; if (obsInst !== memFn(32'h14)) begin nMismatched++; $display("[TB] FAIL frz_inst[%0d]: got %h want %h", i, obsInst, memFn(32'h14)); end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsAddr !== 32'h18) begin nMismatched++; $display("[TB] FAIL frz_resume_addr: got %h want 18", obsAddr); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsPcOut !== 32'h1C) begin nMismatched++; $display("[TB] FAIL frz_resume_pc_out: got %h want 1c", obsPcOut); end
    nCompared++; if (obsAddr !== 32'h1C) begin nMismatched++; $display("[TB] FAIL frz_next_addr: got %h want 1c", obsAddr); end
  endtask

  task automatic test_branch_xfer();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    nCompared++; if (obsAddr !== 32'h20) begin nMismatched++; $display("[TB] FAIL bx_addr: got %h want 20", obsAddr); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bx_valid: got %b want 0", obsValid); end
    nCompared++; if (obsAddr !== 32'h100) begin nMismatched++; $display("[TB] FAIL bx_target: got %h want 100", obsAddr); end
    nCompared++; if (obsInst !== TB_NOP) begin nMismatched++; $display("[TB] FAIL bx_nop: got %h want %h", obsInst, TB_NOP); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsPcOut !== 32'h104) begin nMismatched++; $display("[TB] FAIL bx_pc_out: got %h want 104", obsPcOut); end
    nCompared++; if (obsInst !== memFn(32'h100)) begin nMismatched++; $display("[TB] FAIL bx_inst: got %h want %h", obsInst, memFn(32'h100)); end
  endtask

  task automatic test_branch_drain();
    applyStimulus(1'b0, 1'b1, 32'h30, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
    nCompared++; if (obsAddr !== 32'h30) begin nMismatched++; $display("[TB] FAIL dr_first_addr: got %h want 30", obsAddr); end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    nCompared++; if (obsReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL dr_req_frozen: got %b want 1", obsReq); end
    nCompared++; if (obsAddr !== 32'h30) begin nMismatched++; $display("[TB] FAIL dr_hold_addr: got %h want 30", obsAddr); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsAddr !== 32'h30) begin nMismatched++; $display("[TB] FAIL dr_done_addr: got %h want 30", obsAddr); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsAddr !== 32'h200) begin nMismatched++; $display("[TB] FAIL dr_target: got %h want 200", obsAddr); end
    nCompared++; if (obsValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL dr_discard: got %b want 0", obsValid); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsInst !== memFn(32'h200)) begin nMismatched++; $display("[TB] FAIL dr_inst: got %h want %h", obsInst, memFn(32'h200)); end
    nCompared++; if (obsPcOut !== 32'h204) begin nMismatched++; $display("[TB] FAIL dr_pc_out: got %h want 204", obsPcOut); end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsAddr !== 32'hFFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", obsAddr); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsPcOut !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_pc_out: got %h want 0", obsPcOut); end
    nCompared++; if (obsAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_next_addr: got %h want 0", obsAddr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic f, b, r;
      logic [31:0] ba;
      f  = ($urandom_range(0, 99) < 30);
      b  = ($urandom_range(0, 99) < 10);
      r  = ($urandom_range(0, 99) < 60);
      ba = $urandom & 32'hFFFF_FFFC;
      applyStimulus(f, b, ba, r);
      nCompared++; if (obsReq !== expReq) begin nMismatched++; $display("[TB] FAIL rnd_req[%0d]: got %b want %b", i, obsReq, expReq); end
      nCompared++; if (obsAddr !== expAddr) begin nMismatched++; $display("[TB] FAIL rnd_addr[%0d]: got %h want %h", i, obsAddr, expAddr); end
      nCompared++; if (obsValid !== expValid) begin nMismatched++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", i, obsValid, expValid); end
      nCompared++; if (obsInst !== expInst) begin nMismatched++; $display("[TB] FAIL rnd_inst[%0d]: got %h want %h", i, obsInst, expInst); end
      nCompared++; if (obsPcOut !== expPcOut) begin nMismatched++; $display("[TB] FAIL rnd_pc_out[%0d]: got %h want %h", i, obsPcOut, expPcOut); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] heldAddr;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
    heldAddr = mOutAddr;
    freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0; imem_rdata = memFn(heldAddr);
    #2;
    nCompared++; if (imem_addr !== heldAddr) begin nMismatched++; $display("[TB] FAIL mid_drain_addr: got %h want %h", imem_addr, heldAddr); end
    rst = 1'b1;
    imem_ready = 1'b1;
    #1;
    nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_rst_req: got %b want 1", imem_req); end
    nCompared++; if (imem_addr !== TB_RESET_PC) begin nMismatched++; $display("[TB] FAIL mid_rst_addr: got %h want %h", imem_addr, TB_RESET_PC); end
    nCompared++; if (pc_out !== 32'h4) begin nMismatched++; $display("[TB] FAIL mid_rst_pc_out: got %h want 4", pc_out); end
    nCompared++; if (inst_out !== TB_NOP) begin nMismatched++; $display("[TB] FAIL mid_rst_inst: got %h want %h", inst_out, TB_NOP); end
    nCompared++; if (inst_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_valid: got %b want 0", inst_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL post_rst_addr: got %h want 0", obsAddr); end
    nCompared++; if (obsValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_rst_valid: got %b want 0", obsValid); end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    nCompared++; if (obsInst !== memFn(32'h0)) begin nMismatched++; $display("[TB] FAIL post_rst_inst: got %h want %h", obsInst, memFn(32'h0)); end
    nCompared++; if (obsAddr !== 32'h4) begin nMismatched++; $display("[TB] FAIL post_rst_next: got %h want 4", obsAddr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_freeze();
    test_branch_xfer();
    test_branch_drain();
    test_wrap();
    test_random();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous, active-high reset
REQ-002 The block SHALL expose the following parameters:
  RESET_PC, 32'h0000_0000, first fetch address after reset
  NOP_INST, 32'h0000_0000, instruction presented when no valid instruction is buffered
REQ-003 The block SHALL expose the following ports:
  freeze        in   1   hazard stall; shared with the IF/ID register
  branch_taken  in   1   one-cycle redirect pulse from EXE
  branch_addr   in   32  redirect target
  imem_req      out  1   fetch request
  imem_addr     out  32  fetch word address
  imem_ready    in   1   memory can complete; transfer = imem_req & imem_ready
  imem_rdata    in   32  instruction, valid in the transfer cycle
  pc_out        out  32  PC+4 of buffered instruction, to IF/ID
  inst_out      out  32  buffered instruction, or NOP_INST when empty
  inst_valid    out  1   buffer holds a real instruction

Function
REQ-004 State SHALL be: pc (next fetch address); req_addr (address of the pending request); pend flag; one-entry buffer (buf_inst, buf_pc, buf_valid); FSM {RUN, DRAIN}.
REQ-005 The buffer SHALL drain on every rising edge where freeze=0, matching IF/ID capture; a drain and a load on the same edge SHALL both take effect.
REQ-006 In RUN, imem_req SHALL be 1 iff (buf_valid=0 or freeze=0).
REQ-007 In RUN, imem_addr SHALL be req_addr when pend=1, else pc.
REQ-008 pend SHALL set on a cycle where imem_req=1 and imem_ready=0, and SHALL clear on transfer.
REQ-009 imem_addr SHALL NOT change from first assertion of a request until its transfer.
REQ-010 imem_req MAY drop while pend=1.
REQ-011 In RUN, on a transfer without branch_taken: buf_inst<=imem_rdata, buf_pc<=imem_addr, buf_valid<=1, pc<=imem_addr+4.
REQ-012 Sustained throughput SHALL be one instruction per cycle when imem_ready=1 and freeze=0.
REQ-013 branch_taken SHALL take priority over freeze and over the buffer load: buf_valid<=0 and pc<=branch_addr.
REQ-014 If branch_taken coincides with a transfer, the returned data SHALL be discarded and the FSM SHALL stay in RUN.
REQ-015 If branch_taken occurs with pend=1 and no transfer, the FSM SHALL go to DRAIN.
REQ-016 In DRAIN: imem_req=1 unconditionally; imem_addr=req_addr; transfer data is discarded and the next state is RUN; buf_valid stays 0.
REQ-017 A further branch_taken in DRAIN SHALL overwrite pc and keep the FSM in DRAIN.
REQ-018 Outputs: pc_out = buf_pc+4 (32-bit wrap, carry dropped); inst_out = buf_valid ? buf_inst : NOP_INST; all outputs registered or derived only from registered state and freeze.
REQ-019 A transfer received while buf_valid=1 and freeze=1 SHALL be impossible by construction (REQ-006).

Reset
REQ-020 On rst (asynchronous, effective immediately, mid-transfer included): pc=RESET_PC, req_addr=0, pend=0, buf_valid=0, buf_inst=0, buf_pc=0, FSM=RUN.
REQ-021 During reset, outputs SHALL be: imem_req=1, imem_addr=RESET_PC, pc_out=32'h4, inst_out=NOP_INST, inst_valid=0.
REQ-022 Any memory response in flight at reset SHALL NOT be captured after reset release.

Structure
REQ-023 A shared pipeline package SHALL hold: NOP_INST, the PC increment constant (4), the FSM state enum, and RESET_PC.
REQ-024 The buffer SHALL be a sub-module if_skid_buf (load/drain/clear, one entry); the FSM and PC logic stay in the top module.

Verification
REQ-025 Reset, then imem_ready=1, freeze=0 -> addresses 0,4,8 on consecutive cycles; pc_out 4,8,12; inst_valid=1 from the 2nd cycle onward.
REQ-026 freeze=1 for 3 cycles with the buffer full -> imem_req=0; inst_out/pc_out held; resumes with the next address, no skip and no duplicate.
REQ-027 imem_ready=0 for 2 cycles at address 0x10 -> imem_addr stays 0x10; on ready, buf_pc=0x10 and pc_out=0x14.
REQ-028 branch_taken with branch_addr=0x100 coinciding with a transfer at 0x20 -> data discarded; next request 0x100; inst_valid=0 for one cycle.
REQ-029 branch_taken to 0x200 while 0x30 is pending (ready=0) -> DRAIN; 0x30 is completed and discarded; next imem_addr=0x200.
REQ-030 rst asserted mid-DRAIN -> all outputs take the reset values in the same cycle; first fetch after release is 0x0.
